// File: rtl/wac_ctrl_mc.sv
// wac_ctrl_mc - multi-channel WAC board controller.
//
// Decodes byte commands from the EPP data strobe, loads the WAC
// configuration word, runs counted ADC acquisitions from a selected
// channel into block RAM, and serves BRAM readback to the EPP side.
//
// Build option:
//   WAC_STB_SYNC_EN  when defined, dataStb/dataIn pass through a 2-FF
//                    synchronizer before edge detection (asynchronous
//                    EPP host). When undefined, dataStb is treated as
//                    synchronous to clk.
//
// Ports:
//   clk, rstN      clock and asynchronous active-low reset
//   dataStb        EPP data strobe (active low, byte per 1->0 edge)
//   dataIn         EPP data byte
//   busWacIn       ADC sample, qualified by wacValid
//   busBramIn      BRAM read data (1-cycle read latency)
//   busBramAddr    BRAM address (write ptr, or read ptr in RD_WAIT)
//   busBramOut     BRAM write data, ctrlWeBram its write enable
//   ctrlWac        one-hot channel select during an acquisition
//   confWac        configuration word, confWacEn pulses on update
//   adcWacEn       high while an acquisition runs
//   dataOut        readback byte, dataOutValid its one-cycle qualifier
//   busy           high whenever the FSM is not idle
//
// State table:
//   state     | meaning
//   ----------+-----------------------------------------------------
//   IDLE      | waiting for an opcode byte
//   CONF_RX   | shifting configuration bytes into the shadow register
//   ACQ_CH    | waiting for the channel-select byte
//   ACQ_CNT   | waiting for the sample-count byte
//   ACQ_RUN   | writing samples to BRAM, counting down to zero
//   RD_WAIT   | read pointer on the BRAM address for one cycle

module wac_ctrl_mc #(
  parameter int ADDR_W     = 12,
  parameter int CONF_BYTES = 2,
  parameter int N_CH       = 4
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    dataStb,
  input  logic [7:0]              dataIn,
  input  logic [7:0]              busWacIn,
  input  logic                    wacValid,
  input  logic [7:0]              busBramIn,
  output logic [ADDR_W-1:0]       busBramAddr,
  output logic [7:0]              busBramOut,
  output logic                    ctrlWeBram,
  output logic [7:0]              ctrlWac,
  output logic [8*CONF_BYTES-1:0] confWac,
  output logic                    confWacEn,
  output logic                    adcWacEn,
  output logic [7:0]              dataOut,
  output logic                    dataOutValid,
  output logic                    busy
);

  localparam int CONF_W = 8 * CONF_BYTES;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CC_W   = $clog2(CONF_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONF_RX,
    S_ACQ_CH,
    S_ACQ_CNT,
    S_ACQ_RUN,
    S_RD_WAIT
  } state_t;

  // --------------------------------------------------------------
  // Strobe front end
  // --------------------------------------------------------------
  logic       stb_raw;
  logic [7:0] stb_data;
  logic       stb_prev_q, stb_prev_d;
  logic       stb;

`ifdef WAC_STB_SYNC_EN
  logic       stb_s1_q, stb_s1_d, stb_s2_q, stb_s2_d;
  logic [7:0] din_s1_q, din_s1_d, din_s2_q, din_s2_d;

  always_comb begin
    stb_s1_d = dataStb;
    stb_s2_d = stb_s1_q;
    din_s1_d = dataIn;
    din_s2_d = din_s1_q;
  end

  // Synchronizer resets low so a strobe already low at reset release
  // cannot be mistaken for a fresh falling edge.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stb_s1_q <= 1'b0;
      stb_s2_q <= 1'b0;
      din_s1_q <= 8'h00;
      din_s2_q <= 8'h00;
    end else begin
      stb_s1_q <= stb_s1_d;
      stb_s2_q <= stb_s2_d;
      din_s1_q <= din_s1_d;
      din_s2_q <= din_s2_d;
    end
  end

  assign stb_raw  = stb_s2_q;
  assign stb_data = din_s2_q;
`else
  assign stb_raw  = dataStb;
  assign stb_data = dataIn;
`endif

  // A falling edge needs a sampled 1 first; holding the strobe low
  // therefore yields a single event.
  assign stb_prev_d = stb_raw;
  assign stb        = stb_prev_q & ~stb_raw;

  // --------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wp_q, wp_d;
  logic [ADDR_W-1:0]   rp_q, rp_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [CC_W-1:0]     conf_cnt_q, conf_cnt_d;
  logic [CONF_W-1:0]   shadow_q, shadow_d;
  logic [CONF_W-1:0]   conf_q, conf_d;
  logic                conf_en_q, conf_en_d;
  logic                rd_pend_q, rd_pend_d;

  logic [CONF_W-1:0]   conf_shifted;
  logic [CH_W-1:0]     ch_raw;
  logic [CH_W-1:0]     ch_sel;
  logic                bram_we;
  logic [ADDR_W-1:0]   bram_addr;
  logic                acq_active;

  // Shifting by 8 drops the oldest byte; after CONF_BYTES shifts the
  // first byte received sits in the MSB.
  assign conf_shifted = (shadow_q << 8) | CONF_W'(stb_data);

  // Channel values past the last implemented channel clamp to it.
  assign ch_raw = stb_data[CH_W-1:0];
  assign ch_sel = (32'(ch_raw) >= 32'(N_CH)) ? CH_W'(N_CH - 1) : ch_raw;

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    conf_cnt_d = conf_cnt_q;
    shadow_d   = shadow_q;
    conf_d     = conf_q;
    conf_en_d  = 1'b0;
    rd_pend_d  = 1'b0;
    bram_we    = 1'b0;
    bram_addr  = wp_q;
    acq_active = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (stb) begin
          case (stb_data)
            8'h01: begin
              state_d    = S_CONF_RX;
              conf_cnt_d = '0;
            end
            8'h02: state_d = S_ACQ_CH;
            8'h03: begin
              wp_d = '0;
              rp_d = '0;
            end
            8'h04: state_d = S_RD_WAIT;
            default: ;
          endcase
        end
      end

      S_CONF_RX: begin
        if (stb) begin
          if (conf_cnt_q == CC_W'(CONF_BYTES - 1)) begin
            conf_d    = conf_shifted;
            conf_en_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            shadow_d   = conf_shifted;
            conf_cnt_d = conf_cnt_q + CC_W'(1);
          end
        end
      end

      S_ACQ_CH: begin
        if (stb) begin
          ch_d    = ch_sel;
          state_d = S_ACQ_CNT;
        end
      end

      S_ACQ_CNT: begin
        if (stb) begin
          if (stb_data == 8'h00) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = stb_data;
            state_d = S_ACQ_RUN;
          end
        end
      end

      S_ACQ_RUN: begin
        acq_active = 1'b1;
        // A host byte mid-run is an abort; it wins over a coincident
        // sample so nothing is written once the host has spoken.
        if (stb) begin
          state_d = S_IDLE;
        end else if (wacValid) begin
          bram_we = 1'b1;
          wp_d    = wp_q + ADDR_W'(1);
          cnt_d   = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_IDLE;
          end
        end
      end

      S_RD_WAIT: begin
        // BRAM registers this address at the end of the cycle; its data
        // is on busBramIn the following cycle, flagged by rd_pend_q.
        bram_addr = rp_q;
        rp_d      = rp_q + ADDR_W'(1);
        rd_pend_d = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= S_IDLE;
      stb_prev_q <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      ch_q       <= '0;
      cnt_q      <= 8'h00;
      conf_cnt_q <= '0;
      shadow_q   <= '0;
      conf_q     <= '0;
      conf_en_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stb_prev_q <= stb_prev_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      conf_cnt_q <= conf_cnt_d;
      shadow_q   <= shadow_d;
      conf_q     <= conf_d;
      conf_en_q  <= conf_en_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

  // --------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------
  assign busBramAddr  = bram_addr;
  assign busBramOut   = bram_we ? busWacIn : 8'h00;
  assign ctrlWeBram   = bram_we;
  assign ctrlWac      = acq_active ? (8'd1 << ch_q) : 8'h00;
  assign adcWacEn     = acq_active;
  assign confWac      = conf_q;
  assign confWacEn    = conf_en_q;
  assign dataOut      = rd_pend_q ? busBramIn : 8'h00;
  assign dataOutValid = rd_pend_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_wac_ctrl_mc.sv
module tb_wac_ctrl_mc;

  localparam int ADDR_W     = 12;
  localparam int CONF_BYTES = 2;
  localparam int N_CH       = 4;
`ifdef WAC_STB_SYNC_EN
  localparam int STB_LAT = 2;
`else
  localparam int STB_LAT = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rstN = 1'b0;
  logic                    dataStb = 1'b1;
  logic [7:0]              dataIn = 8'h00;
  logic [7:0]              busWacIn = 8'h00;
  logic                    wacValid = 1'b0;
  logic [7:0]              busBramIn;
  logic [ADDR_W-1:0]       busBramAddr;
  logic [7:0]              busBramOut;
  logic                    ctrlWeBram;
  logic [7:0]              ctrlWac;
  logic [8*CONF_BYTES-1:0] confWac;
  logic                    confWacEn;
  logic                    adcWacEn;
  logic [7:0]              dataOut;
  logic                    dataOutValid;
  logic                    busy;

  int total = 0;
  int bad   = 0;

  wac_ctrl_mc #(.ADDR_W(ADDR_W), .CONF_BYTES(CONF_BYTES), .N_CH(N_CH)) dut (
    .clk(clk), .rstN(rstN), .dataStb(dataStb), .dataIn(dataIn),
    .busWacIn(busWacIn), .wacValid(wacValid), .busBramIn(busBramIn),
    .busBramAddr(busBramAddr), .busBramOut(busBramOut), .ctrlWeBram(ctrlWeBram),
    .ctrlWac(ctrlWac), .confWac(confWac), .confWacEn(confWacEn),
    .adcWacEn(adcWacEn), .dataOut(dataOut), .dataOutValid(dataOutValid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // BRAM model with 1-cycle read latency, plus logs of observed activity.
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_addr [$];
  logic [7:0]        wr_data [$];
  int                conf_en_cnt = 0;
  int                dov_cnt = 0;

  always @(posedge clk) begin
    if (ctrlWeBram === 1'b1) begin
      mem[busBramAddr] <= busBramOut;
      wr_addr.push_back(busBramAddr);
      wr_data.push_back(busBramOut);
    end
    busBramIn <= mem[busBramAddr];
    if (confWacEn === 1'b1) conf_en_cnt++;
    if (dataOutValid === 1'b1) dov_cnt++;
  end

  // Returns at the negedge just after the edge on which the DUT acts.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    dataIn  = b;
    dataStb = 1'b0;
    @(negedge clk);
    dataStb = 1'b1;
    repeat (STB_LAT) @(negedge clk);
  endtask

  task automatic pulse_sample(input logic [7:0] s);
    @(negedge clk);
    busWacIn = s;
    wacValid = 1'b1;
    @(negedge clk);
    wacValid = 1'b0;
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busBramAddr, busBramOut, ctrlWeBram, ctrlWac, confWac, confWacEn,
         adcWacEn, dataOut, dataOutValid, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got addr=%h conf=%h busy=%b exp all zero",
               busBramAddr, confWac, busy);
    end
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || busBramAddr !== '0) begin
      bad++;
      $display("FAIL reset_release got busy=%b addr=%h exp 0 0", busy, busBramAddr);
    end
  endtask

  task automatic test_conf();
    clear_logs();
    conf_en_cnt = 0;
    send_byte(8'h01);
    send_byte(8'hA5);
    total++;
    if (confWac !== 16'h0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL conf_mid got conf=%h busy=%b exp 0000 1", confWac, busy);
    end
    send_byte(8'h3C);
    total++;
    if (confWac !== 16'hA53C || confWacEn !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL conf_load got conf=%h en=%b busy=%b exp a53c 1 0",
               confWac, confWacEn, busy);
    end
    @(negedge clk);
    total++;
    if (confWacEn !== 1'b0 || conf_en_cnt != 1 || wr_addr.size() != 0) begin
      bad++;
      $display("FAIL conf_pulse got en=%b pulses=%0d writes=%0d exp 0 1 0",
               confWacEn, conf_en_cnt, wr_addr.size());
    end
  endtask

  task automatic test_acq_basic();
    clear_logs();
    send_byte(8'h02);
    send_byte(8'h02);
    send_byte(8'h03);
    total++;
    if (ctrlWac !== 8'h04 || adcWacEn !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL acq_start got ctrl=%h en=%b busy=%b exp 04 1 1",
               ctrlWac, adcWacEn, busy);
    end
    for (int i = 0; i < 5; i++) begin
      pulse_sample(8'h10 + 8'(i));
      if (i == 1) begin
        total++;
        if (adcWacEn !== 1'b1) begin
          bad++;
          $display("FAIL acq_still_on got en=%b exp 1", adcWacEn);
        end
      end
      if (i == 2) begin
        total++;
        if (adcWacEn !== 1'b0 || ctrlWac !== 8'h00 || busy !== 1'b0) begin
          bad++;
          $display("FAIL acq_end got en=%b ctrl=%h busy=%b exp 0 00 0",
                   adcWacEn, ctrlWac, busy);
        end
      end
    end
    total++;
    if (wr_addr.size() != 3) begin
      bad++;
      $display("FAIL acq_count got=%0d exp=3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== 8'h10 + 8'(i)) begin
          bad++;
          $display("FAIL acq_write%0d got addr=%h data=%h exp %h %h",
                   i, wr_addr[i], wr_data[i], i, 8'h10 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_readback();
    dov_cnt = 0;
    send_byte(8'h03);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h04);
      total++;
      if (busBramAddr !== ADDR_W'(k) || busy !== 1'b1 || dataOutValid !== 1'b0) begin
        bad++;
        $display("FAIL rd_addr%0d got addr=%h busy=%b dov=%b exp %h 1 0",
                 k, busBramAddr, busy, dataOutValid, k);
      end
      @(negedge clk);
      total++;
      if (dataOutValid !== 1'b1 || dataOut !== 8'h10 + 8'(k)) begin
        bad++;
        $display("FAIL rd_data%0d got dov=%b data=%h exp 1 %h",
                 k, dataOutValid, dataOut, 8'h10 + 8'(k));
      end
      @(negedge clk);
    end
    total++;
    if (dov_cnt != 3 || dataOutValid !== 1'b0) begin
      bad++;
      $display("FAIL rd_pulses got=%0d exp=3", dov_cnt);
    end
  endtask

  task automatic test_abort();
    send_byte(8'h03);
    clear_logs();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'd200);
    total++;
    if (ctrlWac !== 8'h01) begin
      bad++;
      $display("FAIL abort_ch got=%h exp=01", ctrlWac);
    end
    for (int i = 0; i < 50; i++) pulse_sample(8'(i));
    send_byte(8'h55);
    total++;
    if (busy !== 1'b0 || adcWacEn !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle got busy=%b en=%b exp 0 0", busy, adcWacEn);
    end
    pulse_sample(8'hEE);
    pulse_sample(8'hEF);
    total++;
    if (wr_addr.size() != 50 || busBramAddr !== ADDR_W'(50)) begin
      bad++;
      $display("FAIL abort_writes got=%0d ptr=%h exp 50 032", wr_addr.size(), busBramAddr);
    end
    clear_logs();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    pulse_sample(8'h77);
    total++;
    if (wr_addr.size() != 1 || wr_addr[0] !== ADDR_W'(50) || wr_data[0] !== 8'h77) begin
      bad++;
      $display("FAIL abort_resume got n=%0d exp one write 77 at 032", wr_addr.size());
    end
  endtask

  task automatic run_block(input logic [7:0] n);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(n);
    @(negedge clk);
    busWacIn = n;
    wacValid = 1'b1;
    repeat (int'(n)) @(negedge clk);
    wacValid = 1'b0;
  endtask

  task automatic test_wrap();
    send_byte(8'h03);
    clear_logs();
    for (int b = 0; b < 16; b++) run_block(8'd255);
    run_block(8'd15);
    total++;
    if (busBramAddr !== 12'hFFF || wr_addr.size() != 4095) begin
      bad++;
      $display("FAIL wrap_preset got ptr=%h n=%0d exp fff 4095", busBramAddr, wr_addr.size());
    end
    clear_logs();
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    total++;
    if (ctrlWac !== 8'h02) begin
      bad++;
      $display("FAIL wrap_ch got=%h exp=02", ctrlWac);
    end
    pulse_sample(8'hA1);
    pulse_sample(8'hA2);
    total++;
    if (wr_addr.size() != 2) begin
      bad++;
      $display("FAIL wrap_count got=%0d exp=2", wr_addr.size());
    end else begin
      total++;
      if (wr_addr[0] !== 12'hFFF || wr_addr[1] !== 12'h000 || busBramAddr !== 12'h001) begin
        bad++;
        $display("FAIL wrap_addr got %h %h ptr=%h exp fff 000 001",
                 wr_addr[0], wr_addr[1], busBramAddr);
      end
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h03);
    clear_logs();
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h0A);
    total++;
    if (ctrlWac !== 8'h08) begin
      bad++;
      $display("FAIL rmid_ch got=%h exp=08", ctrlWac);
    end
    for (int i = 0; i < 3; i++) pulse_sample(8'h20 + 8'(i));
    @(negedge clk);
    busWacIn = 8'hEE;
    wacValid = 1'b1;
    #1;
    rstN = 1'b0;
    #1;
    total++;
    if (ctrlWeBram !== 1'b0 || adcWacEn !== 1'b0 || ctrlWac !== 8'h00 ||
        busy !== 1'b0 || busBramAddr !== '0 || busBramOut !== 8'h00) begin
      bad++;
      $display("FAIL rmid_outputs got we=%b en=%b ctrl=%h busy=%b addr=%h exp zeros",
               ctrlWeBram, adcWacEn, ctrlWac, busy, busBramAddr);
    end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    wacValid = 1'b0;
    total++;
    if (wr_addr.size() != 3) begin
      bad++;
      $display("FAIL rmid_writes got=%0d exp=3", wr_addr.size());
    end

    send_byte(8'h01);
    send_byte(8'h12);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    total++;
    if (confWac !== 16'h0000 || confWacEn !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rconf_outputs got conf=%h en=%b busy=%b exp 0000 0 0",
               confWac, confWacEn, busy);
    end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    send_byte(8'h01);
    send_byte(8'hBE);
    send_byte(8'hEF);
    total++;
    if (confWac !== 16'hBEEF || confWacEn !== 1'b1) begin
      bad++;
      $display("FAIL rconf_reload got conf=%h en=%b exp beef 1", confWac, confWacEn);
    end
    send_byte(8'h7F);
    total++;
    if (busy !== 1'b0 || confWac !== 16'hBEEF) begin
      bad++;
      $display("FAIL bad_opcode got busy=%b conf=%h exp 0 beef", busy, confWac);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_conf();
    test_acq_basic();
    test_readback();
    test_abort();
    test_wrap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
